// File: rtl/sig_conv_pkg.sv
// Shared constants for the FP <-> sample converters: IEEE-754 double layout,
// sample limits and the converter FSM encoding.
package sig_conv_pkg;

  localparam int DBL_BIAS   = 1023;
  localparam int DBL_EXP_W  = 11;
  localparam int DBL_FRAC_W = 52;
  localparam int SAMPLE_W   = 16;

  localparam logic [14:0] SAMPLE_MAG_MAX = 15'h7FFF;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/double_classify.sv
// Combinational IEEE-754 double classifier: special-value flags, unbiased
// exponent and the right-shift count that aligns the magnitude to a 15-bit integer.
module double_classify
  import sig_conv_pkg::*;
#(
  parameter int BIAS = 1023
) (
  input  logic [DBL_EXP_W-1:0]  i_exp,
  input  logic [DBL_FRAC_W-1:0] i_frac,
  output logic                  o_is_zero_den,
  output logic                  o_is_inf,
  output logic                  o_is_nan,
  output logic signed [11:0]    o_e,
  output logic [3:0]            o_shift
);

  logic w_exp_max;

  assign w_exp_max     = (i_exp == '1);
  assign o_is_zero_den = (i_exp == '0);
  assign o_is_inf      = w_exp_max && (i_frac == '0);
  assign o_is_nan      = w_exp_max && (i_frac != '0);
  assign o_e           = signed'({1'b0, i_exp} - 12'(BIAS));

  // Only exponents 0..14 land inside the 15-bit magnitude; all others are preloaded.
  assign o_shift = (o_e >= 0 && o_e <= 14) ? 4'(14 - o_e) : 4'd0;

endmodule

// File: rtl/double_to_sig16b.sv
// IEEE-754 double to 16-bit sign-magnitude sample, one right-shift per clock.
// Optional build macro ROUND_NEAREST_EN: round half away from zero instead of truncating.
module double_to_sig16b #(
  parameter int SAMPLE_W = 16,
  parameter int DBL_BIAS = 1023
) (
  input  logic                clk_operation,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [63:0]         double,
  output logic [SAMPLE_W-1:0] sig16b,
  output logic                ready,
  output logic                busy,
  output logic                overflow,
  output logic                invalid
);
  import sig_conv_pkg::*;

  localparam int MAG_W = SAMPLE_W - 1;

  logic                r_state;
  logic [3:0]          r_cnt;
  logic                r_sign;
  logic [MAG_W-1:0]    r_mag;
  logic                r_ovf_pend;
  logic                r_inv_pend;
  logic [SAMPLE_W-1:0] r_sig;
  logic                r_ready;
  logic                r_busy;
  logic                r_ovf;
  logic                r_inv;

  logic                w_zero_den;
  logic                w_inf;
  logic                w_nan;
  logic signed [11:0]  w_e;
  logic [3:0]          w_shift;
  logic                w_accept;
  logic                w_done;
  logic [MAG_W-1:0]    w_mag_ld;
  logic                w_ovf_ld;
  logic                w_inv_ld;
  logic [MAG_W-1:0]    w_mag_fin;
  logic                w_carry;

  double_classify #(.BIAS(DBL_BIAS)) u_classify (
    .i_exp         (double[62:52]),
    .i_frac        (double[51:0]),
    .o_is_zero_den (w_zero_den),
    .o_is_inf      (w_inf),
    .o_is_nan      (w_nan),
    .o_e           (w_e),
    .o_shift       (w_shift)
  );

  assign w_accept = (r_state == ST_IDLE) && enable;
  assign w_done   = (r_state == ST_SHIFT) && (r_cnt == 4'd0);

`ifdef ROUND_NEAREST_EN
  logic             r_guard;
  logic             w_grd_ld;
  logic [MAG_W:0]   w_sum;

  always_comb begin
    w_grd_ld = double[37];
    if (w_nan || w_inf || (!w_zero_den && w_e > 14)) begin
      w_grd_ld = 1'b0;
    end else if (w_zero_den || w_e < 0) begin
      // At e = -1 the implicit leading one sits exactly in the guard position.
      w_grd_ld = !w_zero_den && (w_e == -12'sd1);
    end
  end

  assign w_sum     = {1'b0, r_mag} + (MAG_W+1)'(r_guard);
  assign w_carry   = w_sum[MAG_W];
  assign w_mag_fin = w_carry ? SAMPLE_MAG_MAX : w_sum[MAG_W-1:0];

  always_ff @(posedge clk_operation) begin
    if (w_accept) begin
      r_guard <= w_grd_ld;
    end else if (r_state == ST_SHIFT && r_cnt != 4'd0) begin
      r_guard <= r_mag[0];
    end
  end
`else
  assign w_carry   = 1'b0;
  assign w_mag_fin = r_mag;
`endif

  always_comb begin
    w_mag_ld = {1'b1, double[51:38]};
    w_ovf_ld = 1'b0;
    w_inv_ld = 1'b0;
    if (w_nan) begin
      w_mag_ld = '0;
      w_inv_ld = 1'b1;
    end else if (w_inf || (!w_zero_den && w_e > 14)) begin
      w_mag_ld = SAMPLE_MAG_MAX;
      w_ovf_ld = 1'b1;
    end else if (w_zero_den || w_e < 0) begin
      w_mag_ld = '0;
    end
  end

  // Datapath: load on accept, then shift right once per cycle while the count runs.
  always_ff @(posedge clk_operation) begin
    if (w_accept) begin
      r_sign     <= double[63];
      r_mag      <= w_mag_ld;
      r_ovf_pend <= w_ovf_ld;
      r_inv_pend <= w_inv_ld;
    end else if (r_state == ST_SHIFT && r_cnt != 4'd0) begin
      r_mag <= r_mag >> 1;
    end
  end

  always_ff @(posedge clk_operation or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_sig   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
      r_inv   <= 1'b0;
    end else if (w_accept) begin
      r_state <= ST_SHIFT;
      r_cnt   <= w_shift;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_ovf   <= 1'b0;
      r_inv   <= 1'b0;
    end else if (w_done) begin
      r_state <= ST_IDLE;
      // Negative zero collapses to 0x0000.
      r_sig   <= {r_sign & (w_mag_fin != '0), w_mag_fin};
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_ovf   <= r_ovf_pend | w_carry;
      r_inv   <= r_inv_pend;
    end else if (r_state == ST_SHIFT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign sig16b   = r_sig;
  assign ready    = r_ready;
  assign busy     = r_busy;
  assign overflow = r_ovf;
  assign invalid  = r_inv;

endmodule

// File: tb/tb_double_to_sig16b.sv
// Directed-vector bench for double_to_sig16b: table of conversions plus
// hand-written busy, ready-edge and asynchronous-reset sequences.
module tb_double_to_sig16b;

  logic        clk_operation = 1'b0;
  logic        rst_n         = 1'b0;
  logic        enable        = 1'b0;
  logic [63:0] dbl           = '0;
  logic [15:0] sig16b;
  logic        ready, busy, overflow, invalid;

  int n_cmp = 0;
  int n_bad = 0;

  double_to_sig16b dut (
    .clk_operation (clk_operation),
    .rst_n         (rst_n),
    .enable        (enable),
    .double        (dbl),
    .sig16b        (sig16b),
    .ready         (ready),
    .busy          (busy),
    .overflow      (overflow),
    .invalid       (invalid)
  );

  always #5 clk_operation = ~clk_operation;

  typedef struct {
    logic [63:0] d;
    logic [15:0] sig;
    logic        ovf;
    logic        inv;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Wait for ready after an accepting edge; lat counts edges after that edge.
  task automatic wait_ready(inout int lat);
    while (!ready && lat < 40) begin
      @(posedge clk_operation); #1;
      lat++;
    end
  endtask

  task automatic run(input logic [63:0] d, output int lat);
    @(negedge clk_operation);
    enable = 1'b1;
    dbl    = d;
    @(posedge clk_operation); #1;
    enable = 1'b0;
    dbl    = '0;
    lat    = 0;
    wait_ready(lat);
  endtask

  vec_t vecs[$];
  int   lat;

  initial begin
    vecs.push_back('{64'h3FF0000000000000, 16'h0001, 1'b0, 1'b0, 15}); // 1.0
    vecs.push_back('{64'hC08F400000000000, 16'h83E8, 1'b0, 1'b0, 6});  // -1000.0
    vecs.push_back('{64'h40D0000000000000, 16'h4000, 1'b0, 1'b0, 1});  // 16384.0
    vecs.push_back('{64'h40F0000000000000, 16'h7FFF, 1'b1, 1'b0, 1});  // 65536.0
    vecs.push_back('{64'hFFF0000000000000, 16'hFFFF, 1'b1, 1'b0, 1});  // -Inf
    vecs.push_back('{64'h7FF8000000000000, 16'h0000, 1'b0, 1'b1, 1});  // NaN
    vecs.push_back('{64'h40E0000000000000, 16'h7FFF, 1'b1, 1'b0, 1});  // 32768.0
    vecs.push_back('{64'h40DFFFC000000000, 16'h7FFF, 1'b0, 1'b0, 1});  // 32767.0
    vecs.push_back('{64'h8000000000000000, 16'h0000, 1'b0, 1'b0, 1});  // -0.0
    vecs.push_back('{64'h0000000000000001, 16'h0000, 1'b0, 1'b0, 1});  // denormal
`ifdef ROUND_NEAREST_EN
    vecs.push_back('{64'h4004000000000000, 16'h0003, 1'b0, 1'b0, 14}); // 2.5
    vecs.push_back('{64'hBFE8000000000000, 16'h8001, 1'b0, 1'b0, 1});  // -0.75
    vecs.push_back('{64'h3FE0000000000000, 16'h0001, 1'b0, 1'b0, 1});  // 0.5
    vecs.push_back('{64'h40DFFFE000000000, 16'h7FFF, 1'b1, 1'b0, 1});  // 32767.5
`else
    vecs.push_back('{64'h4004000000000000, 16'h0002, 1'b0, 1'b0, 14});
    vecs.push_back('{64'hBFE8000000000000, 16'h0000, 1'b0, 1'b0, 1});
    vecs.push_back('{64'h3FE0000000000000, 16'h0000, 1'b0, 1'b0, 1});
    vecs.push_back('{64'h40DFFFE000000000, 16'h7FFF, 1'b0, 1'b0, 1});
`endif

    #12;
    chk("reset_sig", sig16b, 16'h0);
    chk("reset_ready", ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_flags", {overflow, invalid}, 2'b00);
    @(negedge clk_operation);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run(vecs[i].d, lat);
      chk($sformatf("v%0d_sig", i), sig16b, vecs[i].sig);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
      chk($sformatf("v%0d_inv", i), invalid, vecs[i].inv);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy", i), busy, 1'b0);
    end

    // Enable pulse during a conversion is ignored.
    @(negedge clk_operation);
    enable = 1'b1;
    dbl    = 64'hC08F400000000000;
    @(posedge clk_operation); #1;
    enable = 1'b0;
    chk("busy_set", busy, 1'b1);
    chk("ready_drop", ready, 1'b0);
    @(negedge clk_operation);
    enable = 1'b1;
    dbl    = 64'h3FF0000000000000;
    @(posedge clk_operation); #1;
    enable = 1'b0;
    lat    = 1;
    wait_ready(lat);
    chk("busy_ign_sig", sig16b, 16'h83E8);
    chk("busy_ign_lat", lat, 6);
    run(64'h3FF0000000000000, lat);
    chk("after_busy_sig", sig16b, 16'h0001);
    chk("after_busy_lat", lat, 15);

    // Enable held across the edge where ready rises is ignored.
    @(negedge clk_operation);
    enable = 1'b1;
    dbl    = 64'h40D0000000000000;
    @(posedge clk_operation); #1;
    dbl    = 64'h3FF0000000000000;
    @(posedge clk_operation); #1;
    enable = 1'b0;
    chk("rdy_edge_ready", ready, 1'b1);
    chk("rdy_edge_sig", sig16b, 16'h4000);
    @(posedge clk_operation); #1;
    chk("rdy_edge_hold_ready", ready, 1'b1);
    chk("rdy_edge_hold_busy", busy, 1'b0);

    // Asynchronous reset mid-conversion.
    run(64'h40F0000000000000, lat);
    chk("pre_rst_sig", sig16b, 16'h7FFF);
    @(negedge clk_operation);
    enable = 1'b1;
    dbl    = 64'h3FF0000000000000;
    @(posedge clk_operation); #1;
    enable = 1'b0;
    repeat (3) @(posedge clk_operation);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_sig", sig16b, 16'h0);
    chk("arst_ready", ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_flags", {overflow, invalid}, 2'b00);
    @(negedge clk_operation);
    rst_n = 1'b1;
    run(64'h40D0000000000000, lat);
    chk("post_rst_sig", sig16b, 16'h4000);
    chk("post_rst_lat", lat, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
